mem_stage_hs: RTL and testbench

Parametrised successor to the single-cycle memory stage of the pipelined RISC-V core; sits between the EX/MEM and MEM/WB pipeline registers. Talks to data memory over a req/ack handshake with arbitrary wait states and stalls upstream while an access is outstanding. Generates byte enables for sub-word stores and does lane extraction plus sign or zero extension for loads. Traps misaligned accesses instead of issuing them.

---
 rtl/mem_stage_hs_if.sv | 26 ++
 rtl/mem_stage_hs.sv | 251 +++++++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_hs_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
// The stage holds the request until the memory answers with a single-cycle ack.
interface mem_stage_hs_if #(
   parameter int REG_WIDTH  = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int BE_W = REG_WIDTH / 8;

   logic                  dmem_req;
   logic                  dmem_we;
   logic [ADDR_WIDTH-1:0] dmem_addr;
   logic [BE_W-1:0]       dmem_be;
   logic [REG_WIDTH-1:0]  dmem_wdata;
   logic                  dmem_ack;
   logic [REG_WIDTH-1:0]  dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_hs.sv
// Pipeline memory stage with a req/ack data-memory handshake: sub-word byte enables,
// load lane extraction with sign/zero extension, and trapping of misaligned accesses.
module mem_stage_hs #(
   parameter  int REG_WIDTH  = 32,
   parameter  int REG_BITS   = 5,
   parameter  int ADDR_WIDTH = 32,
   localparam int BE_W       = REG_WIDTH / 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   input  logic [REG_BITS-1:0]  in_rd,
   input  logic                 in_write_en,
   input  logic                 in_mem_read,
   input  logic                 in_mem_write,
   input  logic [1:0]           in_ls_type,
   input  logic                 in_load_unsigned,
   input  logic [1:0]           in_write_src_sel,
   input  logic [REG_WIDTH-1:0] in_alu_out,
   input  logic [REG_WIDTH-1:0] in_store_data,
   input  logic [REG_WIDTH-1:0] in_return_pc,
   output logic                 stall_o,
   mem_stage_hs_if.master       dmem,
   output logic                 wb_valid,
   output logic                 wb_write_en,
   output logic [REG_BITS-1:0]  wb_rd,
   output logic [REG_WIDTH-1:0] wb_alu_out,
   output logic [REG_WIDTH-1:0] wb_load_data,
   output logic [REG_WIDTH-1:0] wb_return_pc,
   output logic [1:0]           wb_write_src_sel,
   output logic                 wb_misalign
);

   localparam int OFF_W = $clog2(BE_W);

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   state_t state, state_nxt;

   logic             memop;
   logic             aligned;
   logic             issue;
   logic             trap;
   logic [OFF_W-1:0] off;

   logic [BE_W-1:0]       be_base;
   logic [BE_W-1:0]       be_nxt;
   logic [REG_WIDTH-1:0]  wdata_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;

   // Request registers: drive the bus unchanged for the whole WAIT period.
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [BE_W-1:0]       r_be;
   logic [REG_WIDTH-1:0]  r_wdata;

   // Instruction fields captured at issue, released to WB on ack.
   logic [REG_BITS-1:0]   l_rd;
   logic                  l_write_en;
   logic [1:0]            l_ls_type;
   logic                  l_load_unsigned;
   logic [1:0]            l_write_src_sel;
   logic [REG_WIDTH-1:0]  l_alu_out;
   logic [REG_WIDTH-1:0]  l_return_pc;
   logic [OFF_W-1:0]      l_off;

   logic [REG_WIDTH-1:0]  shifted;
   logic [REG_WIDTH-1:0]  lane_mask;
   logic                  sign_bit;
   logic [REG_WIDTH-1:0]  load_data;

   assign memop = in_valid & (in_mem_read | in_mem_write);
   assign off   = in_alu_out[OFF_W-1:0];
   assign issue = memop & aligned;
   assign trap  = memop & ~aligned;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      aligned = 1'b0;
      case (in_ls_type)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~off[0];
         2'b10:   aligned = (off[1:0] == 2'b00);
         default: aligned = (REG_WIDTH == 64) && (off == '0);
      endcase
   end

   always_comb begin
      be_base   = '0;
      wdata_nxt = in_store_data;
      case (in_ls_type)
         2'b00: begin
            be_base   = BE_W'(8'h01);
            wdata_nxt = {BE_W{in_store_data[7:0]}};
         end
         2'b01: begin
            be_base   = BE_W'(8'h03);
            wdata_nxt = {(BE_W/2){in_store_data[15:0]}};
         end
         2'b10: begin
            be_base   = BE_W'(8'h0F);
            wdata_nxt = {(BE_W/4){in_store_data[31:0]}};
         end
         default: begin
            be_base   = '1;
            wdata_nxt = in_store_data;
         end
      endcase
   end

   assign be_nxt   = be_base << off;
   assign addr_nxt = {in_alu_out[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

   always_comb begin
      state_nxt = state;
      stall_o   = 1'b0;
      case (state)
         IDLE: begin
            if (issue) begin
               state_nxt = WAIT;
               stall_o   = 1'b1;
            end
         end
         WAIT: begin
            stall_o = ~dmem.dmem_ack;
            if (dmem.dmem_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Upstream must never see a stall while the core is held in reset.
      if (!rstn) stall_o = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_we            <= 1'b0;
         r_addr          <= '0;
         r_be            <= '0;
         r_wdata         <= '0;
         l_rd            <= '0;
         l_write_en      <= 1'b0;
         l_ls_type       <= 2'b00;
         l_load_unsigned <= 1'b0;
         l_write_src_sel <= 2'b00;
         l_alu_out       <= '0;
         l_return_pc     <= '0;
         l_off           <= '0;
      end else if (state == IDLE && issue) begin
         r_we            <= in_mem_write;
         r_addr          <= addr_nxt;
         r_be            <= be_nxt;
         r_wdata         <= wdata_nxt;
         l_rd            <= in_rd;
         l_write_en      <= in_write_en;
         l_ls_type       <= in_ls_type;
         l_load_unsigned <= in_load_unsigned;
         l_write_src_sel <= in_write_src_sel;
         l_alu_out       <= in_alu_out;
         l_return_pc     <= in_return_pc;
         l_off           <= off;
      end
   end

   assign dmem.dmem_req   = (state == WAIT);
   assign dmem.dmem_we    = r_we;
   assign dmem.dmem_addr  = r_addr;
   assign dmem.dmem_be    = r_be;
   assign dmem.dmem_wdata = r_wdata;

   // Sign extension ORs in ~lane_mask, which is zero for full-width loads.
   always_comb begin
      shifted   = dmem.dmem_rdata >> {l_off, 3'b000};
      lane_mask = '1;
      sign_bit  = 1'b0;
      case (l_ls_type)
         2'b00: begin
            lane_mask = REG_WIDTH'(8'hFF);
            sign_bit  = shifted[7];
         end
         2'b01: begin
            lane_mask = REG_WIDTH'(16'hFFFF);
            sign_bit  = shifted[15];
         end
         2'b10: begin
            lane_mask = REG_WIDTH'(32'hFFFF_FFFF);
            sign_bit  = shifted[31];
         end
         default: begin
            lane_mask = '1;
            sign_bit  = 1'b0;
         end
      endcase
      load_data = shifted & lane_mask;
      if (!l_load_unsigned && sign_bit) load_data = load_data | ~lane_mask;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wb_valid         <= 1'b0;
         wb_write_en      <= 1'b0;
         wb_rd            <= '0;
         wb_alu_out       <= '0;
         wb_load_data     <= '0;
         wb_return_pc     <= '0;
         wb_write_src_sel <= 2'b00;
         wb_misalign      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  wb_valid <= 1'b0;
               end else begin
                  wb_valid         <= in_valid;
                  wb_write_en      <= in_write_en & ~trap;
                  wb_rd            <= in_rd;
                  wb_alu_out       <= in_alu_out;
                  wb_load_data     <= '0;
                  wb_return_pc     <= in_return_pc;
                  wb_write_src_sel <= in_write_src_sel;
                  wb_misalign      <= trap;
               end
            end
            WAIT: begin
               if (dmem.dmem_ack) begin
                  wb_valid         <= 1'b1;
                  wb_write_en      <= l_write_en;
                  wb_rd            <= l_rd;
                  wb_alu_out       <= l_alu_out;
                  wb_load_data     <= r_we ? '0 : load_data;
                  wb_return_pc     <= l_return_pc;
                  wb_write_src_sel <= l_write_src_sel;
                  wb_misalign      <= 1'b0;
               end else begin
                  wb_valid <= 1'b0;
               end
            end
            default: wb_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed-vector bench for mem_stage_hs: a driver issues instructions, a memory
// responder acknowledges with scripted wait states, and monitors score bus and WB outputs.
module tb_mem_stage_hs;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic [4:0]  in_rd;
   logic        in_write_en;
   logic        in_mem_read;
   logic        in_mem_write;
   logic [1:0]  in_ls_type;
   logic        in_load_unsigned;
   logic [1:0]  in_write_src_sel;
   logic [31:0] in_alu_out;
   logic [31:0] in_store_data;
   logic [31:0] in_return_pc;
   logic        stall_o;
   logic        wb_valid;
   logic        wb_write_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_alu_out;
   logic [31:0] wb_load_data;
   logic [31:0] wb_return_pc;
   logic [1:0]  wb_write_src_sel;
   logic        wb_misalign;

   mem_stage_hs_if #(.REG_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   mem_stage_hs #(.REG_WIDTH(32), .REG_BITS(5), .ADDR_WIDTH(32)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .in_valid         (in_valid),
      .in_rd            (in_rd),
      .in_write_en      (in_write_en),
      .in_mem_read      (in_mem_read),
      .in_mem_write     (in_mem_write),
      .in_ls_type       (in_ls_type),
      .in_load_unsigned (in_load_unsigned),
      .in_write_src_sel (in_write_src_sel),
      .in_alu_out       (in_alu_out),
      .in_store_data    (in_store_data),
      .in_return_pc     (in_return_pc),
      .stall_o          (stall_o),
      .dmem             (bus),
      .wb_valid         (wb_valid),
      .wb_write_en      (wb_write_en),
      .wb_rd            (wb_rd),
      .wb_alu_out       (wb_alu_out),
      .wb_load_data     (wb_load_data),
      .wb_return_pc     (wb_return_pc),
      .wb_write_src_sel (wb_write_src_sel),
      .wb_misalign      (wb_misalign)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] alu;
      logic [31:0] ld;
      logic [31:0] pc;
      logic [1:0]  wsel;
      logic        mis;
      int unsigned cyc;
   } wb_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wd;
   } req_exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic        wen;
      logic        mrd;
      logic        mwr;
      logic [1:0]  lt;
      logic        uns;
      logic [1:0]  wsel;
      logic [31:0] alu;
      logic [31:0] sd;
      int          waits;
      logic [31:0] rdata;
      logic [31:0] exp_ld;
      int          exp_stall;
      bit          exp_req;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      bit          mis;
   } vec_t;

   wb_exp_t     sb_q[$];
   req_exp_t    rq[$];
   int          resp_w[$];
   logic [31:0] resp_d[$];

   // Memory model: acks after the scripted number of wait cycles for the oldest request.
   initial begin
      int cnt = 0;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         bus.dmem_ack = 1'b0;
         if (!rstn || !bus.dmem_req) begin
            cnt = 0;
         end else if (cnt >= ((resp_w.size() > 0) ? resp_w[0] : 0)) begin
            bus.dmem_ack   = 1'b1;
            bus.dmem_rdata = (resp_d.size() > 0) ? resp_d[0] : 32'h0;
            if (resp_w.size() > 0) void'(resp_w.pop_front());
            if (resp_d.size() > 0) void'(resp_d.pop_front());
            cnt = 0;
         end else begin
            cnt++;
         end
      end
   end

   // Bus monitor: every request cycle must match the oldest expected request.
   always @(negedge clk) begin
      if (rstn && bus.dmem_req) begin
         if (rq.size() == 0) begin
            total++;
            $display("FAIL dmem_unexpected_req: got addr 0x%0h, expected no request", bus.dmem_addr);
         end else begin
            check("dmem_addr", bus.dmem_addr, rq[0].addr);
            check("dmem_we", bus.dmem_we, rq[0].we);
            if (rq[0].we) begin
               check("dmem_be", bus.dmem_be, rq[0].be);
               check("dmem_wdata", bus.dmem_wdata, rq[0].wd);
            end
            if (bus.dmem_ack) void'(rq.pop_front());
         end
      end
   end

   // WB monitor: each wb_valid pulse retires the oldest expected instruction.
   always @(negedge clk) begin
      if (rstn && wb_valid) begin
         if (sb_q.size() == 0) begin
            total++;
            $display("FAIL wb_unexpected_valid: got wb_rd %0d, expected no writeback", wb_rd);
         end else begin
            wb_exp_t e;
            e = sb_q.pop_front();
            check("wb_cycle", cyc, e.cyc);
            check("wb_rd", wb_rd, e.rd);
            check("wb_write_en", wb_write_en, e.wen);
            check("wb_alu_out", wb_alu_out, e.alu);
            check("wb_load_data", wb_load_data, e.ld);
            check("wb_return_pc", wb_return_pc, e.pc);
            check("wb_write_src_sel", wb_write_src_sel, e.wsel);
            check("wb_misalign", wb_misalign, e.mis);
         end
      end
   end

   task automatic drive_idle();
      in_valid         = 1'b0;
      in_rd            = '0;
      in_write_en      = 1'b0;
      in_mem_read      = 1'b0;
      in_mem_write     = 1'b0;
      in_ls_type       = 2'b00;
      in_load_unsigned = 1'b0;
      in_write_src_sel = 2'b00;
      in_alu_out       = '0;
      in_store_data    = '0;
      in_return_pc     = '0;
   endtask

   // Called just after a clock edge; returns just after the edge that accepted the instruction.
   task automatic run_vec(input vec_t v, input logic [31:0] pc);
      wb_exp_t e;
      int      stalls = 0;
      int      guard  = 0;
      logic    st;
      in_valid         = 1'b1;
      in_rd            = v.rd;
      in_write_en      = v.wen;
      in_mem_read      = v.mrd;
      in_mem_write     = v.mwr;
      in_ls_type       = v.lt;
      in_load_unsigned = v.uns;
      in_write_src_sel = v.wsel;
      in_alu_out       = v.alu;
      in_store_data    = v.sd;
      in_return_pc     = pc;
      e.rd   = v.rd;
      e.wen  = v.mis ? 1'b0 : v.wen;
      e.alu  = v.alu;
      e.ld   = v.exp_ld;
      e.pc   = pc;
      e.wsel = v.wsel;
      e.mis  = v.mis;
      e.cyc  = cyc + (v.exp_req ? 2 + v.waits : 1);
      sb_q.push_back(e);
      if (v.exp_req) begin
         rq.push_back('{v.exp_addr, v.mwr, v.exp_be, v.exp_wd});
         resp_w.push_back(v.waits);
         resp_d.push_back(v.rdata);
      end
      forever begin
         @(negedge clk);
         st = stall_o;
         if (st) stalls++;
         @(posedge clk);
         #1;
         if (!st) break;
         guard++;
         if (guard > 100) begin
            total++;
            $display("FAIL stall_timeout: got stall_o stuck high, expected release within 100 cycles");
            break;
         end
      end
      check("stall_cycles", stalls, v.exp_stall);
   endtask

   task automatic check_wb_zero();
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_wb_write_en", wb_write_en, 1'b0);
      check("rst_wb_rd", wb_rd, 5'd0);
      check("rst_wb_alu_out", wb_alu_out, 32'h0);
      check("rst_wb_load_data", wb_load_data, 32'h0);
      check("rst_wb_return_pc", wb_return_pc, 32'h0);
      check("rst_wb_write_src_sel", wb_write_src_sel, 2'b00);
      check("rst_wb_misalign", wb_misalign, 1'b0);
   endtask

   vec_t vecs[11];

   initial begin
      int guard;
      //          rd  wen mrd mwr lt     uns wsel   alu        sd            waits rdata          exp_ld         stl req addr    be       wd            mis
      vecs[0]  = '{5,  1,  0,  0, 2'b00, 0,  2'b00, 32'h1234,  32'h0,        0,    32'h0,         32'h0,         0,  0,  32'h0,  4'b0000, 32'h0,        0};
      vecs[1]  = '{6,  1,  1,  0, 2'b00, 0,  2'b01, 32'h103,   32'h0,        3,    32'h80AABBCC,  32'hFFFFFF80,  4,  1,  32'h100, 4'b0000, 32'h0,       0};
      vecs[2]  = '{7,  1,  1,  0, 2'b00, 1,  2'b01, 32'h103,   32'h0,        1,    32'h80AABBCC,  32'h00000080,  2,  1,  32'h100, 4'b0000, 32'h0,       0};
      vecs[3]  = '{8,  1,  1,  0, 2'b01, 0,  2'b01, 32'h102,   32'h0,        0,    32'h80AABBCC,  32'hFFFF80AA,  1,  1,  32'h100, 4'b0000, 32'h0,       0};
      vecs[4]  = '{9,  1,  1,  0, 2'b01, 1,  2'b01, 32'h102,   32'h0,        2,    32'h80AABBCC,  32'h000080AA,  3,  1,  32'h100, 4'b0000, 32'h0,       0};
      vecs[5]  = '{0,  0,  0,  1, 2'b01, 0,  2'b00, 32'h102,   32'hDEADBEEF, 0,    32'h0,         32'h0,         1,  1,  32'h100, 4'b1100, 32'hBEEFBEEF, 0};
      vecs[6]  = '{0,  0,  0,  1, 2'b00, 0,  2'b00, 32'h101,   32'h12345678, 1,    32'h0,         32'h0,         2,  1,  32'h100, 4'b0010, 32'h78787878, 0};
      vecs[7]  = '{10, 1,  1,  0, 2'b10, 0,  2'b01, 32'h102,   32'h0,        0,    32'h0,         32'h0,         0,  0,  32'h0,  4'b0000, 32'h0,        1};
      vecs[8]  = '{11, 1,  1,  0, 2'b11, 0,  2'b01, 32'h0,     32'h0,        0,    32'h0,         32'h0,         0,  0,  32'h0,  4'b0000, 32'h0,        1};
      vecs[9]  = '{12, 1,  1,  0, 2'b10, 1,  2'b01, 32'h0,     32'h0,        0,    32'hCAFEF00D,  32'hCAFEF00D,  1,  1,  32'h0,  4'b0000, 32'h0,        0};
      vecs[10] = '{0,  0,  0,  1, 2'b10, 0,  2'b00, 32'h4,     32'h0BADC0DE, 2,    32'h0,         32'h0,         3,  1,  32'h4,  4'b1111, 32'h0BADC0DE, 0};

      rstn = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_dmem_req", bus.dmem_req, 1'b0);
      check("rst_stall_o", stall_o, 1'b0);
      rstn = 1'b1;
      @(negedge clk);
      check_wb_zero();

      @(posedge clk);
      #1;
      for (int i = 0; i < 11; i++) run_vec(vecs[i], 32'h1000 + 32'(4 * i));
      drive_idle();

      guard = 0;
      while ((sb_q.size() != 0 || rq.size() != 0) && guard < 50) begin
         @(posedge clk);
         guard++;
      end
      check("drain_wb_pending", sb_q.size(), 0);
      check("drain_req_pending", rq.size(), 0);

      // Reset while a load is waiting: the request and stall must vanish with rstn.
      @(posedge clk);
      #1;
      run_vec('{3, 1, 0, 0, 2'b00, 0, 2'b10, 32'h55AA, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0, 0},
              32'h2000);
      in_valid     = 1'b1;
      in_rd        = 5'd4;
      in_write_en  = 1'b1;
      in_mem_read  = 1'b1;
      in_ls_type   = 2'b10;
      in_alu_out   = 32'h8;
      in_return_pc = 32'h2004;
      rq.push_back('{32'h8, 1'b0, 4'b0000, 32'h0});
      resp_w.push_back(20);
      resp_d.push_back(32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_dmem_req", bus.dmem_req, 1'b1);
      check("pre_rst_stall_o", stall_o, 1'b1);
      rstn = 1'b0;
      #1;
      check("midwait_rst_dmem_req", bus.dmem_req, 1'b0);
      check("midwait_rst_stall_o", stall_o, 1'b0);
      rq.delete();
      resp_w.delete();
      resp_d.delete();
      drive_idle();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      check_wb_zero();
      check("post_rst_dmem_req", bus.dmem_req, 1'b0);
      repeat (3) @(posedge clk);
      check("final_wb_pending", sb_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
